// File: rtl/lblreg_arbiter.sv
// ============================================================================
// Module   : lblreg_arbiter
// Brief    : Round-robin arbitrated writer for a bank of label-tagged registers.
//            H->L downgrades scrub the slot before relabelling it.
//            Optional feature macro: LBLREG_SCRUB_EN (scrub sequence; otherwise
//            downgrades are dropped and flagged on wr_reject).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lblreg_arbiter #(
  parameter int NSLOT = 4,
  parameter int DW    = 8,
  parameter int SW    = $clog2(NSLOT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [SW-1:0] req0_slot,
  input  logic          req0_lbl,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [SW-1:0] req1_slot,
  input  logic          req1_lbl,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic [SW-1:0] rd_slot,
  output logic [DW-1:0] rd_data,
  output logic          rd_lbl,
  output logic          busy,
  output logic          wr_reject
);

  logic             r_ptr;
  logic [NSLOT-1:0] r_lbl;
  logic [DW-1:0]    r_data [NSLOT];
  logic             w_idle;

`ifdef LBLREG_SCRUB_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCRUB  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_lat_slot;
  logic [DW-1:0] r_lat_data;

  assign w_idle    = (r_state == IDLE);
  assign busy      = ~w_idle;
  assign wr_reject = 1'b0;
`else
  logic r_wr_reject;

  assign w_idle    = 1'b1;
  assign busy      = 1'b0;
  assign wr_reject = r_wr_reject;
`endif

  // On contention the pointer names the requester that wins.
  assign req0_ready = w_idle & req0_valid & (~req1_valid | ~r_ptr);
  assign req1_ready = w_idle & req1_valid & (~req0_valid |  r_ptr);

  logic          w_acc;
  logic          w_sel;
  logic [SW-1:0] w_slot;
  logic          w_lbl;
  logic [DW-1:0] w_data;
  logic          w_down;

  assign w_acc  = req0_ready | req1_ready;
  assign w_sel  = req1_ready;
  assign w_slot = w_sel ? req1_slot : req0_slot;
  assign w_lbl  = w_sel ? req1_lbl  : req0_lbl;
  assign w_data = w_sel ? req1_data : req0_data;
  assign w_down = r_lbl[w_slot] & ~w_lbl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= 1'b0;
      r_lbl   <= '0;
      rd_data <= '0;
      rd_lbl  <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        r_data[i] <= '0;
      end
`ifdef LBLREG_SCRUB_EN
      r_state    <= IDLE;
      r_lat_slot <= '0;
      r_lat_data <= '0;
`else
      r_wr_reject <= 1'b0;
`endif
    end else begin
      rd_data <= r_data[rd_slot];
      rd_lbl  <= r_lbl[rd_slot];
`ifndef LBLREG_SCRUB_EN
      r_wr_reject <= 1'b0;
`endif
      if (w_acc) begin
        r_ptr <= ~w_sel;
        if (!w_down) begin
          r_lbl[w_slot]  <= w_lbl;
          r_data[w_slot] <= w_data;
        end else begin
`ifdef LBLREG_SCRUB_EN
          r_lat_slot <= w_slot;
          r_lat_data <= w_data;
          r_state    <= SCRUB;
`else
          r_wr_reject <= 1'b1;
`endif
        end
      end
`ifdef LBLREG_SCRUB_EN
      // Data is cleared while still labelled H, so old H data never pairs with L.
      case (r_state)
        SCRUB: begin
          r_data[r_lat_slot] <= '0;
          r_state            <= COMMIT;
        end
        COMMIT: begin
          r_lbl[r_lat_slot]  <= 1'b0;
          r_data[r_lat_slot] <= r_lat_data;
          r_state            <= IDLE;
        end
        default: ;
      endcase
`endif
    end
  end

endmodule

`default_nettype wire
